// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter with a valid/ready stream on each side.
// Stage k shifts by 2^k when the matching shamt bit is set; the last stage drives the outputs.
module barrel_shifter_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_shamt,
    input  logic [2:0]                 in_opcode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_overflow
);
    localparam int SW = $clog2(WIDTH);

    // One power-of-two shift step; result MSB carries that step's overflow
    function automatic logic [WIDTH:0] stage_op(input logic [WIDTH-1:0] d,
                                                input logic [2:0] op,
                                                input int k);
        int             s;
        logic [WIDTH-1:0] r;
        logic           o;
        s = 32'd1 << k;
        r = d;
        o = 1'b0;
        case (op)
            3'b000: begin
                r = d << s;
                for (int i = 0; i < WIDTH; i++)
                    o = o | ((i >= WIDTH - 1 - s) && (d[i] != d[WIDTH-1]));
            end
            3'b001: begin
                r = d << s;
                for (int i = 0; i < WIDTH; i++)
                    o = o | ((i >= WIDTH - s) && d[i]);
            end
            3'b010:  r = (d << s) | (d >> (WIDTH - s));
            3'b100:  r = $signed(d) >>> s;
            3'b101:  r = d >> s;
            3'b110:  r = (d >> s) | (d << (WIDTH - s));
            default: r = d;
        endcase
        return {o, r};
    endfunction

    logic [WIDTH-1:0] data_r      [SW];
    logic [2:0]       op_r        [SW];
    logic [SW-1:0]    shamt_r     [SW];
    logic [SW-1:0]    ovf_r;
    logic [SW-1:0]    valid_r;
    logic [SW-1:0]    load_s;
    logic [SW-1:0]    src_valid_s;
    logic [SW-1:0]    nxt_ovf_s;
    logic [WIDTH-1:0] nxt_data_s  [SW];
    logic [2:0]       src_op_s    [SW];
    logic [SW-1:0]    src_shamt_s [SW];

    // Backward ready chain: a stage loads when empty or when its successor takes its contents
    always_comb begin : ready_chain
        logic ready_v;
        load_s  = '0;
        ready_v = out_ready;
        for (int k = SW - 1; k >= 0; k--) begin
            ready_v   = !valid_r[k] || ready_v;
            load_s[k] = ready_v;
        end
    end

    // Per-stage source selection and shift datapath
    always_comb begin : datapath
        logic [WIDTH-1:0] sd;
        logic [WIDTH:0]   res;
        logic             sovf;
        int               pk;
        src_valid_s = '0;
        nxt_ovf_s   = '0;
        for (int k = 0; k < SW; k++) begin
            pk = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                sd             = in_data;
                src_op_s[k]    = in_opcode;
                src_shamt_s[k] = in_shamt;
                sovf           = 1'b0;
                src_valid_s[k] = in_valid;
            end else begin
                sd             = data_r[pk];
                src_op_s[k]    = op_r[pk];
                src_shamt_s[k] = shamt_r[pk];
                sovf           = ovf_r[pk];
                src_valid_s[k] = valid_r[pk];
            end
            if (src_shamt_s[k][k]) begin
                res = stage_op(sd, src_op_s[k], k);
            end else begin
                res = {1'b0, sd};
            end
            nxt_data_s[k] = res[WIDTH-1:0];
            nxt_ovf_s[k]  = sovf | res[WIDTH];
        end
    end

    // Stage registers; a held stage keeps all of its fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            ovf_r   <= '0;
            for (int k = 0; k < SW; k++) begin
                data_r[k]  <= '0;
                op_r[k]    <= 3'b000;
                shamt_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SW; k++) begin
                if (load_s[k]) begin
                    valid_r[k] <= src_valid_s[k];
                    if (src_valid_s[k]) begin
                        data_r[k]  <= nxt_data_s[k];
                        op_r[k]    <= src_op_s[k];
                        shamt_r[k] <= src_shamt_s[k];
                        ovf_r[k]   <= nxt_ovf_s[k];
                    end
                end
            end
        end
    end

    assign in_ready     = rst_n && load_s[0];
    assign out_valid    = valid_r[SW-1];
    assign out_data     = data_r[SW-1];
    assign out_overflow = ovf_r[SW-1];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench: WIDTH=8 and WIDTH=16 shifters against a plain-arithmetic reference model.
module tb_barrel_shifter_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic v8, r8, ov8, or8, ovf8;
    logic [7:0] d8, od8;
    logic [2:0] s8, op8;
    logic v16, r16, ov16, or16, ovf16;
    logic [15:0] d16, od16;
    logic [3:0] s16;
    logic [2:0] op16;

    barrel_shifter_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_data(d8),
        .in_shamt(s8), .in_opcode(op8), .out_valid(ov8), .out_ready(or8),
        .out_data(od8), .out_overflow(ovf8));

    barrel_shifter_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .in_data(d16),
        .in_shamt(s16), .in_opcode(op16), .out_valid(ov16), .out_ready(or16),
        .out_data(od16), .out_overflow(ovf16));

    typedef struct {logic [15:0] data; logic ovf; int acc; bit lat;} exp_t;
    exp_t q8[$], q16[$];
    exp_t pend8, pend16;
    int cyc = 0, nvec = 0, nerr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Shift semantics from arithmetic: multiply/divide by 2^sh, range checks for overflow
    function automatic exp_t ref_op(input int w, input logic [15:0] d, input logic [2:0] op, input int sh);
        exp_t e;
        longint u, s, m, hi, lo, p;
        m  = (longint'(1) << w) - 1;
        u  = longint'(d) & m;
        s  = (u > (m >> 1)) ? u - (m + 1) : u;
        hi = m >> 1;
        lo = -hi - 1;
        e.ovf = 1'b0; e.acc = 0; e.lat = 1'b0;
        case (op)
            3'b000: begin p = s * (longint'(1) << sh); e.data = 16'(p & m); e.ovf = (p > hi) || (p < lo); end
            3'b001: begin p = u << sh; e.data = 16'(p & m); e.ovf = (p > m); end
            3'b010: e.data = 16'(((u << sh) | (u >> (w - sh))) & m);
            3'b100: e.data = 16'((s >>> sh) & m);
            3'b101: e.data = 16'(u >> sh);
            3'b110: e.data = 16'(((u >> sh) | (u << (w - sh))) & m);
            default: e.data = 16'(u);
        endcase
        return e;
    endfunction

    task automatic drive8(input logic [7:0] d, input logic [2:0] op, input logic [2:0] sh,
                          input logic [7:0] ed, input logic eo, input bit lat);
        v8 = 1'b1; d8 = d; op8 = op; s8 = sh;
        pend8.data = {8'h00, ed}; pend8.ovf = eo; pend8.lat = lat;
    endtask

    task automatic drive16(input logic [15:0] d, input logic [2:0] op, input logic [3:0] sh,
                           input logic [15:0] ed, input logic eo, input bit lat);
        v16 = 1'b1; d16 = d; op16 = op; s16 = sh;
        pend16.data = ed; pend16.ovf = eo; pend16.lat = lat;
    endtask

    // Sample between edges, score outputs, record accepted operands, advance one clock
    task automatic cycle();
        exp_t e;
        #1;
        if (ov8) begin
            if (q8.size() == 0) check("spurious8", 32'(ov8), 32'd0);
            else begin
                check("data8", 32'(od8), 32'(q8[0].data));
                check("ovf8", 32'(ovf8), 32'(q8[0].ovf));
                if (or8) begin
                    e = q8.pop_front();
                    if (e.lat) check("lat8", 32'(cyc), 32'(e.acc + 2));
                end
            end
        end
        if (ov16) begin
            if (q16.size() == 0) check("spurious16", 32'(ov16), 32'd0);
            else begin
                check("data16", 32'(od16), 32'(q16[0].data));
                check("ovf16", 32'(ovf16), 32'(q16[0].ovf));
                if (or16) begin
                    e = q16.pop_front();
                    if (e.lat) check("lat16", 32'(cyc), 32'(e.acc + 3));
                end
            end
        end
        if (v8 && r8) begin e = pend8; e.acc = cyc + 1; q8.push_back(e); end
        if (v16 && r16) begin e = pend16; e.acc = cyc + 1; q16.push_back(e); end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        v8 = 1'b0; d8 = 8'h00; op8 = 3'b000; s8 = 3'd0; or8 = 1'b1;
        v16 = 1'b0; d16 = 16'h0000; op16 = 3'b000; s16 = 4'd0; or16 = 1'b1;
        pend8 = '{16'h0000, 1'b0, 0, 1'b0};
        pend16 = '{16'h0000, 1'b0, 0, 1'b0};
        @(negedge clk);
        check("rst_in_ready8", 32'(r8), 32'd0);
        check("rst_out_valid8", 32'(ov8), 32'd0);
        check("rst_out_data8", 32'(od8), 32'd0);
        check("rst_ovf8", 32'(ovf8), 32'd0);
        check("rst_in_ready16", 32'(r16), 32'd0);
        check("rst_out_valid16", 32'(ov16), 32'd0);
        rst_n = 1'b1;
        cycle();

        drive8(8'ha6, 3'b000, 3'd4, 8'h60, 1'b1, 1'b1); cycle();
        drive8(8'ha6, 3'b001, 3'd3, 8'h30, 1'b1, 1'b1); cycle();
        drive8(8'ha6, 3'b010, 3'd1, 8'h4d, 1'b0, 1'b1); cycle();
        drive8(8'ha6, 3'b100, 3'd3, 8'hf4, 1'b0, 1'b1); cycle();
        drive8(8'ha6, 3'b101, 3'd5, 8'h05, 1'b0, 1'b1); cycle();
        drive8(8'ha6, 3'b110, 3'd2, 8'ha9, 1'b0, 1'b1); cycle();
        drive8(8'h40, 3'b000, 3'd1, 8'h80, 1'b1, 1'b1); cycle();
        drive8(8'h20, 3'b000, 3'd1, 8'h40, 1'b0, 1'b1); cycle();
        drive8(8'h0f, 3'b001, 3'd4, 8'hf0, 1'b0, 1'b1); cycle();
        drive8(8'h5a, 3'b011, 3'd5, 8'h5a, 1'b0, 1'b1); cycle();
        drive8(8'hc3, 3'b111, 3'd5, 8'hc3, 1'b0, 1'b1); cycle();
        drive8(8'ha6, 3'b000, 3'd0, 8'ha6, 1'b0, 1'b1); cycle();
        drive8(8'h80, 3'b001, 3'd0, 8'h80, 1'b0, 1'b1); cycle();
        v8 = 1'b0;
        repeat (4) cycle();

        // Backpressure: three fill the pipe, the fourth waits for the first pop
        or8 = 1'b0;
        drive8(8'h11, 3'b001, 3'd1, 8'h22, 1'b0, 1'b0); #1 check("bp_rdy1", 32'(r8), 32'd1); cycle();
        drive8(8'h33, 3'b101, 3'd1, 8'h19, 1'b0, 1'b0); #1 check("bp_rdy2", 32'(r8), 32'd1); cycle();
        drive8(8'h81, 3'b010, 3'd1, 8'h03, 1'b0, 1'b0); #1 check("bp_rdy3", 32'(r8), 32'd1); cycle();
        drive8(8'hf0, 3'b110, 3'd4, 8'h0f, 1'b0, 1'b0); #1 check("bp_full", 32'(r8), 32'd0);
        check("bp_held_valid", 32'(ov8), 32'd1);
        cycle();
        check("bp_held_data", 32'(od8), 32'h22);
        or8 = 1'b1;
        #1 check("bp_pop_rdy", 32'(r8), 32'd1);
        cycle();
        v8 = 1'b0;
        repeat (5) cycle();

        drive16(16'h8001, 3'b110, 4'd15, 16'h0003, 1'b0, 1'b1); cycle();
        drive16(16'h8000, 3'b100, 4'd15, 16'hffff, 1'b0, 1'b1); cycle();
        drive16(16'h0001, 3'b001, 4'd15, 16'h8000, 1'b0, 1'b1); cycle();
        v16 = 1'b0;
        repeat (5) cycle();

        // Reset with two operands in flight
        drive8(8'ha6, 3'b000, 3'd4, 8'h60, 1'b1, 1'b0); cycle();
        drive8(8'h0f, 3'b001, 3'd4, 8'hf0, 1'b0, 1'b0); cycle();
        v8 = 1'b0;
        rst_n = 1'b0;
        #1 check("midrst_out_valid", 32'(ov8), 32'd0);
        check("midrst_in_ready", 32'(r8), 32'd0);
        q8.delete();
        q16.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            cycle();
            check("post_rst_idle", 32'(ov8), 32'd0);
        end
        check("post_rst_in_ready", 32'(r8), 32'd1);

        repeat (400) begin
            v8 = 1'($urandom_range(0, 1)); d8 = 8'($urandom);
            op8 = 3'($urandom_range(0, 7)); s8 = 3'($urandom_range(0, 7));
            pend8 = ref_op(8, {8'h00, d8}, op8, int'(s8));
            or8 = ($urandom_range(0, 3) != 0);
            v16 = 1'($urandom_range(0, 1)); d16 = 16'($urandom);
            op16 = 3'($urandom_range(0, 7)); s16 = 4'($urandom_range(0, 15));
            pend16 = ref_op(16, d16, op16, int'(s16));
            or16 = ($urandom_range(0, 3) != 0);
            cycle();
        end
        v8 = 1'b0; v16 = 1'b0; or8 = 1'b1; or16 = 1'b1;
        repeat (8) cycle();
        check("drain8", 32'(q8.size()), 32'd0);
        check("drain16", 32'(q16.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
